// File: rtl/memresp_pkg.sv
// Shared types and constants for the mem_responder data-memory target.
package memresp_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int MASK_W = 8;
    localparam int REG_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        BURST_RD,
        BURST_WR
    } state_t;

    // Mask bit 7 names R0 and bit 0 names R7.
    function automatic logic [REG_W-1:0] mask_to_reg(input logic [REG_W-1:0] bitpos);
        return REG_W'(MASK_W - 1) - bitpos;
    endfunction

endpackage

// File: rtl/memresp_mask_scan.sv
// Finds the next register to service in an LM/SM mask (lowest register number first).
module memresp_mask_scan
    import memresp_pkg::*;
(
    input  logic [MASK_W-1:0] i_mask,
    output logic [REG_W-1:0]  o_reg,
    output logic              o_found,
    output logic              o_is_last
);

    // Scan upward so the highest set bit (the lowest register number) wins.
    always_comb begin
        o_reg     = '0;
        o_found   = 1'b0;
        for (int i = 0; i < MASK_W; i++) begin
            if (i_mask[i]) begin
                o_reg   = mask_to_reg(REG_W'(i));
                o_found = 1'b1;
            end
        end
        o_is_last = o_found && ((i_mask & (i_mask - MASK_W'(1))) == '0);
    end

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: single and LM/SM burst accesses to a word-addressed array.
// Optional build macro MEMRESP_BOUNDS_CHK_EN: addresses >= DEPTH suppress writes,
// read back 0 and flag rsp_err on that beat.
module mem_responder
    import memresp_pkg::*;
#(
    parameter int DEPTH    = 256,
    parameter int READ_LAT = 2
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [MASK_W-1:0] req_mask,
    output logic              wbeat_ready,
    output logic [REG_W-1:0]  wbeat_reg,
    input  logic              wbeat_valid,
    input  logic [DATA_W-1:0] wbeat_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [REG_W-1:0]  rsp_reg,
    output logic              rsp_last,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [MASK_W-1:0]   r_mask_rem;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [READ_LAT-1:0] r_pipe_vld;
    logic [READ_LAT-1:0] r_pipe_last;
    logic [READ_LAT-1:0] r_pipe_err;
    logic [REG_W-1:0]    r_pipe_reg  [READ_LAT];
    logic [DATA_W-1:0]   r_pipe_data [READ_LAT];

    logic                r_wack_vld;
    logic                r_wack_last;
    logic                r_wack_err;
    logic [REG_W-1:0]    r_wack_reg;

    logic                w_idle;
    logic [MASK_W-1:0]   w_scan_mask;
    logic [REG_W-1:0]    w_scan_reg;
    logic                w_scan_found;
    logic                w_scan_last;
    logic [MASK_W-1:0]   w_scan_bit;
    logic                w_accept;
    logic                w_rd_issue;
    logic                w_wbeat_hs;
    logic                w_single_wr;
    logic                w_beat_adv;
    logic [IDX_W-1:0]    w_rd_idx;
    logic                w_rd_oob;
    logic                w_wr_oob;
    logic                w_acc_oob;
    logic                w_mem_we;
    logic [DATA_W-1:0]   w_mem_wdata;

    // In IDLE the scanner looks at the incoming mask so beat 0 of a read burst issues on accept.
    assign w_idle      = (r_state == IDLE);
    assign w_scan_mask = w_idle ? req_mask : r_mask_rem;

    memresp_mask_scan u_scan (
        .i_mask    (w_scan_mask),
        .o_reg     (w_scan_reg),
        .o_found   (w_scan_found),
        .o_is_last (w_scan_last)
    );

    assign w_scan_bit  = MASK_W'(1 << (MASK_W - 1)) >> w_scan_reg;
    assign w_accept    = w_idle & req_valid;
    assign w_rd_issue  = (w_accept & ~req_we) | ((r_state == BURST_RD) & w_scan_found);
    assign w_wbeat_hs  = (r_state == BURST_WR) & w_scan_found & wbeat_valid;
    assign w_single_wr = (r_state == SINGLE) & r_we;
    assign w_beat_adv  = (w_accept & ~req_we & w_scan_found)
                       | ((r_state == BURST_RD) & w_scan_found)
                       | w_wbeat_hs;
    assign w_rd_idx    = w_idle ? req_addr[IDX_W-1:0] : r_addr[IDX_W-1:0];

`ifdef MEMRESP_BOUNDS_CHK_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    logic [ADDR_W-1:0] w_rd_addr;
    assign w_rd_addr = w_idle ? req_addr : r_addr;
    assign w_rd_oob  = ({1'b0, w_rd_addr} >= DEPTH_L);
    assign w_wr_oob  = ({1'b0, r_addr}    >= DEPTH_L);
    assign w_acc_oob = ({1'b0, req_addr}  >= DEPTH_L);
`else
    assign w_rd_oob  = 1'b0;
    assign w_wr_oob  = 1'b0;
    assign w_acc_oob = 1'b0;
`endif

    // Write acks and read returns never coexist: each request completes before the next is taken.
    assign rsp_valid = r_pipe_vld[READ_LAT-1] | r_wack_vld;
    assign rsp_data  = r_pipe_vld[READ_LAT-1] ? r_pipe_data[READ_LAT-1] : '0;
    assign rsp_reg   = r_pipe_vld[READ_LAT-1] ? r_pipe_reg[READ_LAT-1]
                     : (r_wack_vld ? r_wack_reg : '0);
    assign rsp_last  = (r_pipe_vld[READ_LAT-1] & r_pipe_last[READ_LAT-1]) | (r_wack_vld & r_wack_last);
    assign rsp_err   = (r_pipe_vld[READ_LAT-1] & r_pipe_err[READ_LAT-1])  | (r_wack_vld & r_wack_err);

    // Next-state and handshake outputs; every busy state ends on the final response.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        wbeat_ready = 1'b0;
        wbeat_reg   = '0;
        unique case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_mask == '0)  w_state_nxt = SINGLE;
                    else if (req_we)     w_state_nxt = BURST_WR;
                    else                 w_state_nxt = BURST_RD;
                end
            end
            BURST_WR: begin
                wbeat_ready = w_scan_found;
                wbeat_reg   = w_scan_found ? w_scan_reg : '0;
                if (rsp_last) w_state_nxt = IDLE;
            end
            default: begin
                if (rsp_last) w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset_n) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Request capture, beat sequencing and valid flags of the response paths.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_addr     <= '0;
            r_mask_rem <= '0;
            r_we       <= 1'b0;
            r_pipe_vld <= '0;
            r_wack_vld <= 1'b0;
        end else begin
            if (w_accept) r_we <= req_we;
            if (w_accept | w_beat_adv) begin
                r_mask_rem <= w_scan_mask & ~(w_beat_adv ? w_scan_bit : '0);
                r_addr     <= (w_accept ? req_addr : r_addr) + ADDR_W'(w_beat_adv);
            end
            r_pipe_vld[0] <= w_rd_issue;
            for (int i = 1; i < READ_LAT; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
            r_wack_vld <= (w_accept & req_we & (req_mask == '0)) | w_wbeat_hs;
        end
    end

    // Read-latency pipe payload and write-ack payload (qualified by the valid flags).
    always_ff @(posedge clk) begin
        if (w_accept) r_wdata <= req_wdata;
        r_pipe_data[0] <= w_rd_oob ? '0 : r_mem[w_rd_idx];
        r_pipe_reg[0]  <= w_scan_found ? w_scan_reg : '0;
        r_pipe_last[0] <= w_scan_found ? w_scan_last : 1'b1;
        r_pipe_err[0]  <= w_rd_oob;
        for (int i = 1; i < READ_LAT; i++) begin
            r_pipe_data[i] <= r_pipe_data[i-1];
            r_pipe_reg[i]  <= r_pipe_reg[i-1];
            r_pipe_last[i] <= r_pipe_last[i-1];
            r_pipe_err[i]  <= r_pipe_err[i-1];
        end
        r_wack_reg  <= w_wbeat_hs ? w_scan_reg : '0;
        r_wack_last <= w_wbeat_hs ? w_scan_last : 1'b1;
        r_wack_err  <= w_wbeat_hs ? w_wr_oob : w_acc_oob;
    end

    assign w_mem_we    = (w_single_wr | w_wbeat_hs) & ~w_wr_oob & ~reset_n;
    assign w_mem_wdata = w_single_wr ? r_wdata : wbeat_data;

    // Array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_addr[IDX_W-1:0]] <= w_mem_wdata;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder with a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_responder;

    localparam int L     = 2;
    localparam int DEPTH = 256;
`ifdef MEMRESP_BOUNDS_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic [2:0]  rg;
        logic        last;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [7:0]  req_mask;
    logic        wbeat_ready;
    logic [2:0]  wbeat_reg;
    logic        wbeat_valid;
    logic [15:0] wbeat_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [2:0]  rsp_reg;
    logic        rsp_last;
    logic        rsp_err;

    mem_responder #(.DEPTH(DEPTH), .READ_LAT(L)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_mask    (req_mask),
        .wbeat_ready (wbeat_ready),
        .wbeat_reg   (wbeat_reg),
        .wbeat_valid (wbeat_valid),
        .wbeat_data  (wbeat_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_reg     (rsp_reg),
        .rsp_last    (rsp_last),
        .rsp_err     (rsp_err)
    );

    always #5 clk = ~clk;

    int   cyc  = 0;
    int   nvec = 0;
    int   nerr = 0;
    bit   chk_en = 1'b0;
    rsp_t expq[$];
    rsp_t rxq[$];
    rsp_t cmp_got;
    rsp_t cmp_exp;
    logic [15:0] mem_m [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic m_oob(input logic [15:0] a);
        return CHK && (a >= 16'(DEPTH));
    endfunction

    function automatic logic [15:0] m_rd(input logic [15:0] a);
        return m_oob(a) ? 16'h0000 : mem_m[a[7:0]];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Every cycle: the DUT response must be the oldest expected one, at its scheduled cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            if (expq.size() > 0 && expq[0].cyc < cyc) begin
                nvec++;
                nerr++;
                $display("FAIL rsp_missing: nothing at cycle %0d, expected reg %0d data %h",
                         expq[0].cyc, expq[0].rg, expq[0].data);
                void'(expq.pop_front());
            end
            if (rsp_valid !== 1'b0) begin
                cmp_got = '{cyc, rsp_data, rsp_reg, rsp_last, rsp_err};
                rxq.push_back(cmp_got);
                nvec++;
                if (expq.size() == 0) begin
                    nerr++;
                    $display("FAIL rsp_unexpected: cycle %0d reg %0d data %h last %b",
                             cyc, rsp_reg, rsp_data, rsp_last);
                end else begin
                    cmp_exp = expq.pop_front();
                    if (rsp_valid !== 1'b1 || cmp_got.cyc != cmp_exp.cyc ||
                        cmp_got.data !== cmp_exp.data || cmp_got.rg !== cmp_exp.rg ||
                        cmp_got.last !== cmp_exp.last || cmp_got.err !== cmp_exp.err) begin
                        nerr++;
                        $display("FAIL rsp_fields: got cyc %0d reg %0d data %h last %b err %b, expected cyc %0d reg %0d data %h last %b err %b",
                                 cmp_got.cyc, cmp_got.rg, cmp_got.data, cmp_got.last, cmp_got.err,
                                 cmp_exp.cyc, cmp_exp.rg, cmp_exp.data, cmp_exp.last, cmp_exp.err);
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int g;
        g = 0;
        while ((expq.size() != 0 || req_ready !== 1'b1) && g < 64) begin
            @(posedge clk); #1;
            g++;
        end
        if (expq.size() != 0 || req_ready !== 1'b1) begin
            nvec++;
            nerr++;
            $display("FAIL idle_timeout: %0d responses outstanding, req_ready %b", expq.size(), req_ready);
            expq.delete();
        end
    endtask

    // Issues one request and queues the responses the specification demands for it.
    task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [7:0] mask, input int smin, input int smax,
                          input bit wait_done, output int acc);
        int          guard;
        int          k;
        int          nb;
        logic [15:0] a;
        logic [15:0] d;
        rsp_t        e;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (req_ready !== 1'b1) begin
            nvec++;
            nerr++;
            $display("FAIL req_ready_timeout: responder never became idle");
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_mask = mask;
        @(posedge clk); #1;
        acc = cyc;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        req_mask  = 8'($urandom);
        check("req_ready_busy", 32'(req_ready), 32'd0);
        nb = $countones(mask);
        k  = 0;
        if (mask == 8'h00) begin
            if (we) begin
                e = '{acc, 16'h0000, 3'd0, 1'b1, m_oob(addr)};
                if (!m_oob(addr)) mem_m[addr[7:0]] = wdata;
            end else begin
                e = '{acc + L - 1, m_rd(addr), 3'd0, 1'b1, m_oob(addr)};
            end
            expq.push_back(e);
        end else if (!we) begin
            for (int r = 0; r < 8; r++) begin
                if (mask[7-r]) begin
                    a = addr + 16'(k);
                    e = '{acc + L - 1 + k, m_rd(a), 3'(r), (k == nb - 1), m_oob(a)};
                    expq.push_back(e);
                    k++;
                end
            end
        end else begin
            for (int r = 0; r < 8; r++) begin
                if (mask[7-r]) begin
                    a = addr + 16'(k);
                    repeat ($urandom_range(smax, smin)) begin
                        check("wbeat_ready_stall", 32'(wbeat_ready), 32'd1);
                        check("wbeat_reg_stall", 32'(wbeat_reg), 32'(r));
                        @(posedge clk); #1;
                    end
                    check("wbeat_ready", 32'(wbeat_ready), 32'd1);
                    check("wbeat_reg", 32'(wbeat_reg), 32'(r));
                    d = 16'($urandom);
                    wbeat_valid = 1'b1; wbeat_data = d;
                    @(posedge clk); #1;
                    wbeat_valid = 1'b0; wbeat_data = 16'($urandom);
                    e = '{cyc, 16'h0000, 3'(r), (k == nb - 1), m_oob(a)};
                    expq.push_back(e);
                    if (!m_oob(a)) mem_m[a[7:0]] = d;
                    k++;
                end
            end
        end
        if (wait_done) wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          c;
        logic        we;
        logic [7:0]  mask;
        logic [15:0] addr;

        reset_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_mask = '0; wbeat_valid = 1'b0; wbeat_data = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        check("rst_req_ready",   32'(req_ready),   32'd1);
        check("rst_rsp_valid",   32'(rsp_valid),   32'd0);
        check("rst_wbeat_ready", 32'(wbeat_ready), 32'd0);
        check("rst_wbeat_reg",   32'(wbeat_reg),   32'd0);
        check("rst_rsp_data",    32'(rsp_data),    32'd0);
        check("rst_rsp_last",    32'(rsp_last),    32'd0);
        check("rst_rsp_err",     32'(rsp_err),     32'd0);
        chk_en = 1'b1;

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) do_req(1'b1, 16'(i), 16'($urandom), 8'h00, 0, 0, 1'b1, acc);

        // Single write then single read.
        rxq.delete();
        do_req(1'b1, 16'h0010, 16'h1234, 8'h00, 0, 0, 1'b1, acc);
        check("sw_ack_cycle", 32'(rxq[0].cyc), 32'(acc));
        check("sw_ack_last",  32'(rxq[0].last), 32'd1);
        rxq.delete();
        do_req(1'b0, 16'h0010, 16'h0000, 8'h00, 0, 0, 1'b1, acc);
        check("lw_count", 32'(rxq.size()), 32'd1);
        check("lw_data",  32'(rxq[0].data), 32'h1234);
        check("lw_cycle", 32'(rxq[0].cyc), 32'(acc + 1));
        check("lw_last",  32'(rxq[0].last), 32'd1);

        // LM mask 0xA1 -> R0, R2, R7 from three consecutive words.
        do_req(1'b1, 16'h0020, 16'hA0A0, 8'h00, 0, 0, 1'b1, acc);
        do_req(1'b1, 16'h0021, 16'hB0B0, 8'h00, 0, 0, 1'b1, acc);
        do_req(1'b1, 16'h0022, 16'hC0C0, 8'h00, 0, 0, 1'b1, acc);
        rxq.delete();
        do_req(1'b0, 16'h0020, 16'h0000, 8'hA1, 0, 0, 1'b1, acc);
        check("lm_count", 32'(rxq.size()), 32'd3);
        check("lm_r0",    {13'd0, rxq[0].rg, rxq[0].data}, {13'd0, 3'd0, 16'hA0A0});
        check("lm_r2",    {13'd0, rxq[1].rg, rxq[1].data}, {13'd0, 3'd2, 16'hB0B0});
        check("lm_r7",    {13'd0, rxq[2].rg, rxq[2].data}, {13'd0, 3'd7, 16'hC0C0});
        check("lm_lasts", {29'd0, rxq[0].last, rxq[1].last, rxq[2].last}, 32'b001);
        check("lm_end_cycle", 32'(rxq[2].cyc), 32'(acc + 3));

        // SM mask 0x03 with a five-cycle stall before each beat, then read back.
        rxq.delete();
        do_req(1'b1, 16'h0030, 16'h0000, 8'h03, 5, 5, 1'b1, acc);
        check("sm_count", 32'(rxq.size()), 32'd2);
        check("sm_regs",  {26'd0, rxq[0].rg, rxq[1].rg}, {26'd0, 3'd6, 3'd7});
        check("sm_lasts", {30'd0, rxq[0].last, rxq[1].last}, 32'b01);
        do_req(1'b0, 16'h0030, 16'h0000, 8'hC0, 0, 0, 1'b1, acc);

        // Address wrap 0xFFFF -> 0x0000 inside an LM.
        do_req(1'b1, 16'hFFFF, 16'hBEEF, 8'h00, 0, 0, 1'b1, acc);
        do_req(1'b1, 16'h0000, 16'hCAFE, 8'h00, 0, 0, 1'b1, acc);
        rxq.delete();
        do_req(1'b0, 16'hFFFF, 16'h0000, 8'hC0, 0, 0, 1'b1, acc);
        check("wrap_count", 32'(rxq.size()), 32'd2);
        check("wrap_b0", {12'd0, rxq[0].err, rxq[0].rg, rxq[0].data},
              {12'd0, CHK, 3'd0, (CHK ? 16'h0000 : 16'hBEEF)});
        check("wrap_b1", {11'd0, rxq[1].last, rxq[1].err, rxq[1].rg, rxq[1].data},
              {11'd0, 1'b1, 1'b0, 3'd1, 16'hCAFE});

        // Write just past the array: suppressed with the check, aliases index 0 without it.
        rxq.delete();
        do_req(1'b1, 16'h0100, 16'h7777, 8'h00, 0, 0, 1'b1, acc);
        check("oob_ack_err", 32'(rxq[0].err), 32'(CHK));
        rxq.delete();
        do_req(1'b0, 16'h0000, 16'h0000, 8'h00, 0, 0, 1'b1, acc);
        check("oob_idx0", 32'(rxq[0].data), (CHK ? 32'h0000CAFE : 32'h00007777));

        // Reset held three cycles in the middle of an 8-beat LM.
        do_req(1'b0, 16'h0040, 16'h0000, 8'hFF, 0, 0, 1'b0, acc);
        repeat (2) begin @(posedge clk); #1; end
        c = cyc;
        reset_n = 1'b1;
        while (expq.size() > 0 && expq[expq.size()-1].cyc > c) void'(expq.pop_back());
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("rst_rel_req_ready", 32'(req_ready), 32'd1);
        check("rst_rel_rsp_valid", 32'(rsp_valid), 32'd0);
        do_req(1'b0, 16'h0040, 16'h0000, 8'hFF, 0, 0, 1'b1, acc);

        // Random mix of single and burst accesses.
        for (int n = 0; n < 120; n++) begin
            we   = 1'($urandom_range(0, 1));
            mask = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            case ($urandom_range(0, 7))
                0:       addr = 16'($urandom);
                1:       addr = 16'hFFF8 + 16'($urandom_range(0, 7));
                2:       addr = 16'h00F8 + 16'($urandom_range(0, 7));
                default: addr = 16'($urandom_range(0, 255));
            endcase
            do_req(we, addr, 16'($urandom), mask, 0, 3, 1'b1, acc);
        end

        repeat (4) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
